// File: rtl/mux_scan_serializer.sv
// Sequencer around an 8:1 mux: latch a word, step sel through all channels,
// sample Y per channel, emit serial bits plus a recaptured byte and compare.
module mux_scan_serializer #(
  parameter int SETTLE_CYC = 2,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic [7:0] i_bus,
  output logic [2:0] sel,
  input  logic       y_in,
  output logic       ser_out,
  output logic       ser_valid,
  output logic [7:0] cap_data,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [2:0] FIRST = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] LAST  = MSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [3:0] CNT_END = 4'(SETTLE_CYC - 1);

  state_t     state;
  logic [3:0] cnt;

  // Scan sequencer: settle, sample, step channel; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      i_bus     <= '0;
      sel       <= '0;
      cap_data  <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ser_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            i_bus    <= data_in;
            cap_data <= '0;
            err      <= 1'b0;
            sel      <= FIRST;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= SETTLE;
          end else begin
            busy <= 1'b0;
          end
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_END) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          cap_data[sel] <= y_in;
          ser_out       <= y_in;
          ser_valid     <= 1'b1;
          if (sel == LAST) begin
            state <= DONE;
          end else begin
            sel   <= MSB_FIRST ? sel - 3'd1 : sel + 3'd1;
            cnt   <= '0;
            state <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b1;
          err   <= (cap_data != i_bus);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Bench for mux_scan_serializer: three instances (LSB/S=2, MSB/S=2, LSB/S=1)
// each closed around a behavioural 8:1 mux with optional per-channel fault.
module tb_mux_scan_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start [3];
  logic [7:0] din   [3];
  logic [7:0] flip  [3];
  logic [7:0] ibus  [3];
  logic [7:0] cap   [3];
  logic [2:0] sel   [3];
  logic       y     [3];
  logic       so    [3];
  logic       sv    [3];
  logic       busy  [3];
  logic       done  [3];
  logic       err   [3];

  int n_checks = 0;
  int n_fail   = 0;

  assign y[0] = ibus[0][sel[0]] ^ flip[0][sel[0]];
  assign y[1] = ibus[1][sel[1]] ^ flip[1][sel[1]];
  assign y[2] = ibus[2][sel[2]] ^ flip[2][sel[2]];

  mux_scan_serializer #(.SETTLE_CYC(2), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .data_in(din[0]),
    .i_bus(ibus[0]), .sel(sel[0]), .y_in(y[0]), .ser_out(so[0]),
    .ser_valid(sv[0]), .cap_data(cap[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]));

  mux_scan_serializer #(.SETTLE_CYC(2), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .data_in(din[1]),
    .i_bus(ibus[1]), .sel(sel[1]), .y_in(y[1]), .ser_out(so[1]),
    .ser_valid(sv[1]), .cap_data(cap[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]));

  mux_scan_serializer #(.SETTLE_CYC(1), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .data_in(din[2]),
    .i_bus(ibus[2]), .sel(sel[2]), .y_in(y[2]), .ser_out(so[2]),
    .ser_valid(sv[2]), .cap_data(cap[2]), .busy(busy[2]),
    .done(done[2]), .err(err[2]));

  // observations of the most recent scan
  logic [7:0]  ob_stream;
  logic [23:0] ob_selseq;
  int          ob_nstrobe;
  int          ob_edges[$];
  int          ob_done_edge;
  int          ob_ndone;
  logic [7:0]  ob_cap;
  logic [7:0]  ob_ibus;
  logic        ob_err;
  logic        ob_busy_after;
  int          ob_busy_low;

  // reference model: settle length and scan order per instance
  function automatic int m_settle(input int u);
    return (u == 2) ? 1 : 2;
  endfunction

  function automatic bit m_msb(input int u);
    return (u == 1);
  endfunction

  function automatic int m_ch(input bit msb, input int i);
    return msb ? 7 - i : i;
  endfunction

  function automatic logic [7:0] m_stream(input logic [7:0] d,
                                          input logic [7:0] f,
                                          input bit msb);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[7-i] = d[m_ch(msb, i)] ^ f[m_ch(msb, i)];
    end
    return r;
  endfunction

  function automatic logic [23:0] m_selseq(input bit msb);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r = {r[20:0], 3'(m_ch(msb, i))};
    end
    return r;
  endfunction

  function automatic bit m_edges_ok(input int s);
    if (ob_edges.size() != 8) return 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ob_edges[k] != (k + 1) * (s + 1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drive one scan on instance u and record everything it emits.
  task automatic run_scan(input int u, input logic [7:0] d,
                          input logic [7:0] f, input int restart_edge);
    logic [2:0] psel;
    ob_stream = '0;
    ob_selseq = '0;
    ob_nstrobe = 0;
    ob_edges.delete();
    ob_done_edge = -1;
    ob_ndone = 0;
    ob_cap = '0;
    ob_ibus = '0;
    ob_err = 1'b0;
    ob_busy_after = 1'b1;
    ob_busy_low = 0;
    @(negedge clk);
    din[u] = d;
    flip[u] = f;
    start[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[u] = 1'b0;
    din[u] = 8'($urandom);
    psel = sel[u];
    for (int e = 1; e <= 60; e++) begin
      start[u] = (e == restart_edge);
      @(posedge clk);
      @(negedge clk);
      if (sv[u]) begin
        ob_stream = {ob_stream[6:0], so[u]};
        ob_selseq = {ob_selseq[20:0], psel};
        ob_nstrobe++;
        ob_edges.push_back(e);
      end
      if (done[u]) begin
        ob_ndone++;
        if (ob_done_edge < 0) begin
          ob_done_edge = e;
          ob_cap = cap[u];
          ob_err = err[u];
          ob_ibus = ibus[u];
        end
      end
      if (ob_done_edge < 0 && !busy[u]) ob_busy_low++;
      if (ob_done_edge >= 0 && e == ob_done_edge + 1) ob_busy_after = busy[u];
      psel = sel[u];
      if (ob_done_edge >= 0 && e >= ob_done_edge + 3) break;
    end
    start[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      n_checks++;
      if ({ibus[u], sel[u], cap[u], so[u], sv[u], busy[u], done[u], err[u]} !== '0) begin
        n_fail++;
        $display("FAIL reset_u%0d: got ibus=%h sel=%0d cap=%h so=%b sv=%b busy=%b done=%b err=%b exp all 0",
                 u, ibus[u], sel[u], cap[u], so[u], sv[u], busy[u], done[u], err[u]);
      end
    end
  endtask

  task automatic test_lsb_fixed();
    run_scan(0, 8'h35, 8'h00, 0);
    n_checks++;
    if (ob_stream !== 8'b1010_1100 || ob_nstrobe != 8) begin
      n_fail++;
      $display("FAIL lsb_stream: got %b (%0d strobes) exp 10101100 (8)", ob_stream, ob_nstrobe);
    end
    n_checks++;
    if (ob_selseq !== 24'o01234567) begin
      n_fail++;
      $display("FAIL lsb_selseq: got %o exp 01234567", ob_selseq);
    end
    n_checks++;
    if (ob_done_edge != 25 || ob_ndone != 1) begin
      n_fail++;
      $display("FAIL lsb_done: got edge %0d count %0d exp edge 25 count 1", ob_done_edge, ob_ndone);
    end
    n_checks++;
    if (ob_cap !== 8'h35 || ob_err !== 1'b0 || ob_ibus !== 8'h35) begin
      n_fail++;
      $display("FAIL lsb_cap: got cap=%h err=%b ibus=%h exp 35 0 35", ob_cap, ob_err, ob_ibus);
    end
    n_checks++;
    if (ob_busy_low != 0 || ob_busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_busy: got low=%0d after=%b exp 0 0", ob_busy_low, ob_busy_after);
    end
  endtask

  task automatic test_msb_fixed();
    run_scan(1, 8'hA6, 8'h00, 0);
    n_checks++;
    if (ob_stream !== 8'b1010_0110 || ob_nstrobe != 8) begin
      n_fail++;
      $display("FAIL msb_stream: got %b (%0d strobes) exp 10100110 (8)", ob_stream, ob_nstrobe);
    end
    n_checks++;
    if (ob_selseq !== 24'o76543210) begin
      n_fail++;
      $display("FAIL msb_selseq: got %o exp 76543210", ob_selseq);
    end
    n_checks++;
    if (ob_cap !== 8'hA6 || ob_err !== 1'b0 || ob_done_edge != 25) begin
      n_fail++;
      $display("FAIL msb_cap: got cap=%h err=%b edge=%0d exp a6 0 25", ob_cap, ob_err, ob_done_edge);
    end
  endtask

  task automatic test_err_hold();
    bit ended;
    run_scan(0, 8'h81, 8'h81, 0);
    n_checks++;
    if (ob_cap !== 8'h00 || ob_err !== 1'b1 || ob_done_edge != 25) begin
      n_fail++;
      $display("FAIL err_set: got cap=%h err=%b edge=%0d exp 00 1 25", ob_cap, ob_err, ob_done_edge);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (err[0] !== 1'b1 || cap[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL err_hold: got err=%b cap=%h exp 1 00", err[0], cap[0]);
    end
    din[0] = 8'h55;
    flip[0] = 8'h00;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    n_checks++;
    if (err[0] !== 1'b0 || cap[0] !== 8'h00 || busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b cap=%h busy=%b exp 0 00 1", err[0], cap[0], busy[0]);
    end
    ended = 1'b0;
    for (int i = 0; i < 40 && !ended; i++) begin
      @(negedge clk);
      if (done[0]) ended = 1'b1;
    end
    n_checks++;
    if (!ended || cap[0] !== 8'h55 || err[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL err_rescan: got ended=%b cap=%h err=%b exp 1 55 0", ended, cap[0], err[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    logic [7:0] d;
    d = 8'($urandom);
    run_scan(0, d, 8'h00, 10);
    n_checks++;
    if (ob_done_edge != 25 || ob_ndone != 1) begin
      n_fail++;
      $display("FAIL restart_done: got edge %0d count %0d exp 25 1", ob_done_edge, ob_ndone);
    end
    n_checks++;
    if (ob_cap !== d || ob_stream !== m_stream(d, 8'h00, 1'b0) || ob_nstrobe != 8) begin
      n_fail++;
      $display("FAIL restart_data: got cap=%h stream=%b n=%0d exp %h %b 8",
               ob_cap, ob_stream, ob_nstrobe, d, m_stream(d, 8'h00, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    din[0] = 8'h5A;
    flip[0] = 8'h00;
    start[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      if (e == 8) rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b0;
    n_checks++;
    if ({ibus[0], sel[0], cap[0], so[0], sv[0], busy[0], done[0], err[0]} !== '0) begin
      n_fail++;
      $display("FAIL midreset: got ibus=%h sel=%0d cap=%h so=%b sv=%b busy=%b done=%b err=%b exp all 0",
               ibus[0], sel[0], cap[0], so[0], sv[0], busy[0], done[0], err[0]);
    end
    run_scan(0, 8'hFF, 8'h00, 0);
    n_checks++;
    if (ob_cap !== 8'hFF || ob_err !== 1'b0 || ob_done_edge != 25) begin
      n_fail++;
      $display("FAIL midreset_rescan: got cap=%h err=%b edge=%0d exp ff 0 25", ob_cap, ob_err, ob_done_edge);
    end
  endtask

  task automatic test_settle1();
    logic [7:0] d;
    d = 8'($urandom);
    run_scan(2, d, 8'h00, 0);
    n_checks++;
    if (!m_edges_ok(1)) begin
      n_fail++;
      $display("FAIL settle1_strobes: got %0d strobes first at %0d exp 8 at edges 2,4..16",
               ob_edges.size(), (ob_edges.size() > 0) ? ob_edges[0] : -1);
    end
    n_checks++;
    if (ob_done_edge != 17 || ob_cap !== d || ob_ndone != 1) begin
      n_fail++;
      $display("FAIL settle1_done: got edge=%0d cap=%h n=%0d exp 17 %h 1", ob_done_edge, ob_cap, ob_ndone, d);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int         u;
      int         s;
      bit         msb;
      logic [7:0] d;
      logic [7:0] f;
      logic [7:0] ec;
      u = i % 3;
      s = m_settle(u);
      msb = m_msb(u);
      d = 8'($urandom);
      f = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      run_scan(u, d, f, 0);
      ec = d ^ f;
      n_checks++;
      if (ob_stream !== m_stream(d, f, msb) || ob_selseq !== m_selseq(msb) || !m_edges_ok(s)) begin
        n_fail++;
        $display("FAIL rnd%0d_stream: u%0d got %b sel %o exp %b sel %o",
                 i, u, ob_stream, ob_selseq, m_stream(d, f, msb), m_selseq(msb));
      end
      n_checks++;
      if (ob_cap !== ec || ob_err !== (f != 8'h00) || ob_ibus !== d
          || ob_done_edge != 8 * (s + 1) + 1 || ob_ndone != 1) begin
        n_fail++;
        $display("FAIL rnd%0d_result: u%0d got cap=%h err=%b ibus=%h edge=%0d n=%0d exp %h %b %h %0d 1",
                 i, u, ob_cap, ob_err, ob_ibus, ob_done_edge, ob_ndone,
                 ec, (f != 8'h00), d, 8 * (s + 1) + 1);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      start[u] = 1'b0;
      din[u] = '0;
      flip[u] = '0;
    end
    test_reset();
    test_lsb_fixed();
    test_msb_fixed();
    test_err_hold();
    test_restart_ignored();
    test_reset_mid();
    test_settle1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
